syscall_sequencer: RTL

- Sequences multi-cycle environment calls from the RISC-V pipeline onto a set of peripheral devices (LED, mouse, UART TX/RX).
- Latches function code (a7) and argument (a0) on `ecall`, then stalls the pipeline.
- Issues a one-hot req/ack handshake to the selected device and returns its data as `eret` with a one-cycle `eret_valid`.
- Sits between the EX stage and the peripheral bus, and owns the global `nHalt`.

---
 rtl/syscall_sequencer_pkg.sv | 34 +++
 rtl/syscall_sequencer_if.sv | 30 +++
 rtl/syscall_sequencer_decode.sv | 29 ++
 rtl/syscall_sequencer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/syscall_sequencer_pkg.sv
// syscall_pkg: function codes, device lane indices, FSM state type and the
// debug snapshot shared by the syscall sequencer, its decoder and benches.
package syscall_pkg;

    // Syscall function codes (low byte of a7)
    localparam logic [7:0] SYS_HALT  = 8'h0a;
    localparam logic [7:0] SYS_LED   = 8'h22;
    localparam logic [7:0] SYS_MOUSE = 8'h80;
    localparam logic [7:0] SYS_PUTC  = 8'h0b;
    localparam logic [7:0] SYS_GETC  = 8'h0c;

    // Device request/ack lane assignment
    localparam int DEV_LED   = 0;
    localparam int DEV_MOUSE = 1;
    localparam int DEV_PUTC  = 2;
    localparam int DEV_GETC  = 3;

    // Value returned in eret when a device never acknowledges
    localparam logic [31:0] ERET_TIMEOUT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        DONE   = 2'd2,
        HALTED = 2'd3
    } sys_state_t;

    // Internal state made visible for checkers
    typedef struct packed {
        sys_state_t state;
        logic [7:0] code;
    } sys_dbg_t;

endpackage

// File: rtl/syscall_sequencer_if.sv
// Peripheral-side bus of the syscall sequencer.
//
// Handshake: the master raises exactly one dev_req bit and holds it, together
// with dev_arg, until it samples the matching dev_ack bit high at a rising
// clock edge; dev_req then drops the following cycle. dev_ack may be driven
// combinationally from dev_req, so an ack in the first request cycle is legal.
// dev_rdata lane d (bits [32d+31:32d]) is captured on that same edge.
// Ack bits on lanes that are not requested carry no meaning.
interface syscall_sequencer_if #(
    parameter int NDEV = 4
);
    logic [NDEV-1:0]    dev_req;
    logic [31:0]        dev_arg;
    logic [NDEV-1:0]    dev_ack;
    logic [NDEV*32-1:0] dev_rdata;

    modport master (
        output dev_req,
        output dev_arg,
        input  dev_ack,
        input  dev_rdata
    );

    modport slave (
        input  dev_req,
        input  dev_arg,
        output dev_ack,
        output dev_rdata
    );
endinterface

// File: rtl/syscall_sequencer_decode.sv
// syscall_decode: maps the syscall function code onto a one-hot device
// lane, a halt request or an unknown code. Purely combinational.
module syscall_decode
    import syscall_pkg::*;
#(
    parameter int NDEV = 4
) (
    input  logic [7:0]      code,
    output logic [NDEV-1:0] dev,
    output logic            is_halt,
    output logic            is_unknown
);

    // Table lookup of the function code
    always_comb begin
        dev        = '0;
        is_halt    = 1'b0;
        is_unknown = 1'b0;
        case (code)
            SYS_HALT:  is_halt          = 1'b1;
            SYS_LED:   dev[DEV_LED]     = 1'b1;
            SYS_MOUSE: dev[DEV_MOUSE]   = 1'b1;
            SYS_PUTC:  dev[DEV_PUTC]    = 1'b1;
            SYS_GETC:  dev[DEV_GETC]    = 1'b1;
            default:   is_unknown       = 1'b1;
        endcase
    end

endmodule

// File: rtl/syscall_sequencer.sv
// syscall_sequencer: turns an ecall in EX into a request/ack transaction on
// one peripheral lane, stalls the pipeline meanwhile and returns the device
// data as eret with a one-cycle eret_valid. Also owns the CPU halt (nHalt).
//
// Optional feature macro SYSCALL_TIMEOUT_EN: abandons a request after TO_CYC
// cycles without ack, returning ERET_TIMEOUT and setting a sticky
// timeout_flag. Without it a request waits forever and timeout_flag is 0.
module syscall_sequencer
    import syscall_pkg::*;
#(
    parameter int NDEV   = 4,
    parameter int TO_CYC = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ecall,
    input  logic [31:0] a7,
    input  logic [31:0] a0,
    output logic        stall,
    output logic [31:0] eret,
    output logic        eret_valid,
    output logic        nHalt,
    output logic        timeout_flag,
    output sys_dbg_t    dbg,
    syscall_sequencer_if.master bus
);

    sys_state_t      state;
    logic [7:0]      code;
    logic [NDEV-1:0] dev_sel;
    logic [NDEV-1:0] dec_dev;
    logic            dec_halt;
    logic            dec_unknown;
    logic            ack_hit;
    logic [31:0]     sel_rdata;

    // Only the low byte of a7 selects the syscall
    logic [23:0] unused_a7_hi;
    assign unused_a7_hi = a7[31:8];

    syscall_decode #(.NDEV(NDEV)) u_decode (
        .code       (a7[7:0]),
        .dev        (dec_dev),
        .is_halt    (dec_halt),
        .is_unknown (dec_unknown)
    );

    // Ack qualified by the lane actually requested; other lanes are ignored
    assign ack_hit = |(bus.dev_ack & dev_sel);

    // Read-data lane mux driven by the latched one-hot selection
    always_comb begin
        sel_rdata = '0;
        for (int d = 0; d < NDEV; d++) begin
            if (dev_sel[d]) begin
                sel_rdata = sel_rdata | bus.dev_rdata[32*d +: 32];
            end
        end
    end

    // Stall: in IDLE follows ecall so the ecall cannot leave EX before it is served
    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = ecall;
            REQ:     stall = 1'b1;
            DONE:    stall = 1'b0;
            HALTED:  stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    assign dbg = '{state: state, code: code};

`ifdef SYSCALL_TIMEOUT_EN
    logic [9:0] to_cnt;
`else
    logic [9:0] unused_to_cyc;
    assign unused_to_cyc = 10'(TO_CYC);
    assign timeout_flag  = 1'b0;
`endif

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            code         <= '0;
            dev_sel      <= '0;
            eret         <= '0;
            eret_valid   <= 1'b0;
            nHalt        <= 1'b1;
            bus.dev_req  <= '0;
            bus.dev_arg  <= '0;
`ifdef SYSCALL_TIMEOUT_EN
            to_cnt       <= '0;
            timeout_flag <= 1'b0;
`endif
        end else begin
            eret_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ecall) begin
                        code        <= a7[7:0];
                        bus.dev_arg <= a0;
                        if (dec_halt) begin
                            nHalt <= 1'b0;
                            state <= HALTED;
                        end else if (dec_unknown) begin
                            eret       <= '0;
                            eret_valid <= 1'b1;
                            state      <= DONE;
                        end else begin
                            dev_sel     <= dec_dev;
                            bus.dev_req <= dec_dev;
`ifdef SYSCALL_TIMEOUT_EN
                            to_cnt      <= '0;
`endif
                            state       <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (ack_hit) begin
                        eret        <= sel_rdata;
                        eret_valid  <= 1'b1;
                        bus.dev_req <= '0;
                        state       <= DONE;
`ifdef SYSCALL_TIMEOUT_EN
                    end else if (to_cnt == 10'(TO_CYC - 1)) begin
                        // This is the TO_CYC-th cycle without ack: give up
                        eret         <= ERET_TIMEOUT;
                        eret_valid   <= 1'b1;
                        bus.dev_req  <= '0;
                        timeout_flag <= 1'b1;
                        state        <= DONE;
                    end else begin
                        to_cnt <= to_cnt + 10'd1;
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
